seq_magnitude_comparator: RTL and testbench

Parametrised, multi-cycle magnitude comparator that extends the four-bit combinational comparator of EXP 02 to arbitrary WIDTH.
- Compares operands A and B DIGIT bits per clock, most-significant chunk first.
- Terminates early on the first differing chunk.
- Supports unsigned and two's-complement signed modes.
- Uses a start/busy/done handshake, so it can sit behind a lab datapath or sequencer that issues one comparison at a time.

---
 rtl/seq_magnitude_comparator.sv | 136 +++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator. Operands are compared DIGIT bits per
// clock, most-significant chunk first. The compare stops at the first chunk
// that differs. Signed operands are turned into offset-binary when they are
// captured, so one unsigned chunk compare serves both modes.
module seq_magnitude_comparator #(
    parameter  int unsigned WIDTH  = 16,
    parameter  int unsigned DIGIT  = 4,
    localparam int unsigned NCHUNK = WIDTH / DIGIT,
    localparam int unsigned CNTW   = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [3:0]       R,
    output logic [CNTW-1:0]  cycles
);

    // Result encodings {NE, GT, EQ, LT}
    localparam logic [3:0] RES_LT = 4'b1001;
    localparam logic [3:0] RES_EQ = 4'b0010;
    localparam logic [3:0] RES_GT = 4'b1100;

    localparam logic [CNTW-1:0]  LAST_CHUNK = CNTW'(NCHUNK);
    localparam logic [WIDTH-1:0] MSB_MASK   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [3:0]       r_q, r_d;
    logic [CNTW-1:0]  cycles_q, cycles_d;

    logic [DIGIT-1:0] chunk_a;
    logic [DIGIT-1:0] chunk_b;
    logic [CNTW-1:0]  cnt_inc;
    logic [WIDTH-1:0] sign_flip;

    assign chunk_a   = sa_q[WIDTH-1 -: DIGIT];
    assign chunk_b   = sb_q[WIDTH-1 -: DIGIT];
    assign cnt_inc   = cnt_q + CNTW'(1);
    assign sign_flip = signed_mode ? MSB_MASK : '0;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            r_q      <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            cycles_q <= cycles_d;
        end
    end

    // Next-state, operand capture/shift and result decision.
    // The decision is written into the result register on the edge that
    // enters DONE, so R and cycles become visible together with done.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        cycles_d = cycles_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = A ^ sign_flip;
                    sb_d    = B ^ sign_flip;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                cnt_d = cnt_inc;
                if (chunk_a != chunk_b) begin
                    r_d      = (chunk_a > chunk_b) ? RES_GT : RES_LT;
                    cycles_d = cnt_inc;
                    state_d  = S_DONE;
                end else if (cnt_inc == LAST_CHUNK) begin
                    r_d      = RES_EQ;
                    cycles_d = cnt_inc;
                    state_d  = S_DONE;
                end else begin
                    sa_d = sa_q << DIGIT;
                    sb_d = sb_q << DIGIT;
                end
            end

            S_DONE: begin
                // A start here is taken immediately so back-to-back
                // comparisons lose no cycle.
                state_d = S_IDLE;
                if (start) begin
                    sa_d    = A ^ sign_flip;
                    sb_d    = B ^ sign_flip;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy   = (state_q == S_RUN);
        done   = (state_q == S_DONE);
        R      = r_q;
        cycles = cycles_q;
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: a 16/4 instance and a legacy 4/1
// instance, table vectors, random vectors and handshake corner cases.
module tb_seq_magnitude_comparator;

    localparam logic [3:0] LT = 4'b1001;
    localparam logic [3:0] EQ = 4'b0010;
    localparam logic [3:0] GT = 4'b1100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [3:0]  r16;
    logic [2:0]  cyc16;

    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4;
    logic [3:0]  r4;
    logic [2:0]  cyc4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] r;
        int         k;
        int         due;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [3:0]  r;
        int          k;
    } vec_t;

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
        .A(a16), .B(b16), .busy(busy16), .done(done16), .R(r16), .cycles(cyc16)
    );

    seq_magnitude_comparator #(.WIDTH(4), .DIGIT(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .A(a4), .B(b4), .busy(busy4), .done(done4), .R(r4), .cycles(cyc4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Scoreboard: compare each done pulse against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done16) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done16_unexpected actual=1 expected=0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q16.pop_front();
                chk("r16", 32'(r16), 32'(e.r));
                chk("cycles16", 32'(cyc16), 32'(e.k));
                chk("latency16", 32'(cyc), 32'(e.due));
            end
        end
        if (rst_n && done4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done4_unexpected actual=1 expected=0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("r4", 32'(r4), 32'(e.r));
                chk("cycles4", 32'(cyc4), 32'(e.k));
                chk("latency4", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called at a negedge; returns just after the capture edge
    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        input logic [3:0] r, input int k, input bit push);
        exp_t e;
        start16 = 1'b1; a16 = a; b16 = b; sm16 = sm;
        @(posedge clk);
        #1;
        if (push) begin
            e.r = r; e.k = k; e.due = cyc + k;
            q16.push_back(e);
        end
        start16 = 1'b0;
        a16 = $urandom; b16 = $urandom; sm16 = $urandom;
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] r, input int k);
        exp_t e;
        start4 = 1'b1; a4 = a; b4 = b; sm4 = 1'b0;
        @(posedge clk);
        #1;
        e.r = r; e.k = k; e.due = cyc + k;
        q4.push_back(e);
        start4 = 1'b0;
        a4 = 4'($urandom);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q16.size() == 0 && q4.size() == 0) break;
        end
        if (q16.size() != 0 || q4.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d expected=0 pending", name, q16.size() + q4.size());
            q16.delete();
            q4.delete();
        end
    endtask

    // Independent reference: native compare, first differing nibble
    task automatic model16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                           output logic [3:0] r, output int k);
        logic [15:0] diff;
        if (sm) r = ($signed(a) < $signed(b)) ? LT : (($signed(a) > $signed(b)) ? GT : EQ);
        else    r = (a < b) ? LT : ((a > b) ? GT : EQ);
        diff = a ^ b;
        k = 4;
        for (int c = 3; c >= 0; c--) begin
            if (((diff >> (4 * c)) & 16'hF) != 16'h0) begin
                k = 4 - c;
                break;
            end
        end
    endtask

    vec_t t16[12];
    vec_t t4[6];

    initial begin
        t16[0]  = '{16'h5000, 16'hA000, 1'b0, LT, 1};
        t16[1]  = '{16'h1234, 16'h1235, 1'b0, LT, 4};
        t16[2]  = '{16'hCCCC, 16'hCCCC, 1'b0, EQ, 4};
        t16[3]  = '{16'h8000, 16'h0001, 1'b1, LT, 1};
        t16[4]  = '{16'h8000, 16'h0001, 1'b0, GT, 1};
        t16[5]  = '{16'hFFFF, 16'h0000, 1'b1, LT, 1};
        t16[6]  = '{16'h7FFF, 16'h8000, 1'b1, GT, 1};
        t16[7]  = '{16'hFFFE, 16'hFFFF, 1'b1, LT, 4};
        t16[8]  = '{16'h0000, 16'h0000, 1'b1, EQ, 4};
        t16[9]  = '{16'hAB00, 16'hAC00, 1'b0, LT, 2};
        t16[10] = '{16'h12F0, 16'h1200, 1'b1, GT, 3};
        t16[11] = '{16'hFFFF, 16'hFFFF, 1'b0, EQ, 4};

        t4[0] = '{16'h5, 16'hA, 1'b0, LT, 1};
        t4[1] = '{16'hC, 16'hC, 1'b0, EQ, 4};
        t4[2] = '{16'h3, 16'h5, 1'b0, LT, 2};
        t4[3] = '{16'hC, 16'hA, 1'b0, GT, 2};
        t4[4] = '{16'h0, 16'h1, 1'b0, LT, 4};
        t4[5] = '{16'hF, 16'hE, 1'b0, GT, 4};

        // Reset state
        #1;
        chk("rst_busy16", 32'(busy16), 0);
        chk("rst_done16", 32'(done16), 0);
        chk("rst_r16", 32'(r16), 0);
        chk("rst_cycles16", 32'(cyc16), 0);
        chk("rst_r4", 32'(r4), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, one at a time
        foreach (t16[i]) begin
            go16(t16[i].a, t16[i].b, t16[i].sm, t16[i].r, t16[i].k, 1'b1);
            drain("table16");
        end
        foreach (t4[i]) begin
            go4(t4[i].a[3:0], t4[i].b[3:0], t4[i].r, t4[i].k);
            drain("table4");
        end

        // Random vectors, some sharing leading chunks
        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra, rb;
            logic [3:0]  rr;
            logic        rs;
            int          rk;
            ra = 16'($urandom);
            rb = (i % 2 == 1) ? (ra ^ (16'h1 << $urandom_range(0, 15))) : 16'($urandom);
            if (i % 7 == 0) rb = ra;
            rs = 1'($urandom);
            model16(ra, rb, rs, rr, rk);
            go16(ra, rb, rs, rr, rk, 1'b1);
            drain("random16");
        end

        // Start while busy is ignored; start in DONE is taken back-to-back
        go16(16'h0FFF, 16'h0FFE, 1'b0, GT, 4, 1'b1);
        @(negedge clk);
        chk("busy_in_run", 32'(busy16), 1);
        go16(16'h0000, 16'hFFFF, 1'b0, LT, 1, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done16) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("b2b_done_seen", 32'(seen), 1);
        end
        go16(16'h0000, 16'hFFFF, 1'b0, LT, 1, 1'b1);
        drain("b2b");
        repeat (4) @(negedge clk);

        // Reset during RUN aborts the comparison
        go16(16'h1111, 16'h1112, 1'b0, LT, 4, 1'b0);
        @(negedge clk);
        chk("abort_busy_before", 32'(busy16), 1);
        #1 rst_n = 1'b0;
        #3;
        chk("abort_busy", 32'(busy16), 0);
        chk("abort_done", 32'(done16), 0);
        chk("abort_r", 32'(r16), 0);
        chk("abort_cycles", 32'(cyc16), 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_r_hold", 32'(r16), 0);
        chk("abort_cycles_hold", 32'(cyc16), 0);
        go16(16'h1111, 16'h1112, 1'b0, LT, 4, 1'b1);
        drain("after_abort");

        // R and cycles hold between done pulses
        repeat (3) @(negedge clk);
        chk("hold_r", 32'(r16), 32'(LT));
        chk("hold_cycles", 32'(cyc16), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
